sparse_chunk_encoder: RTL
=========================

Name: sparse_chunk_encoder

Overview:
- Packs a dense chunk of CHUNK_N elements into the sparse format consumed by the downstream prefix-sum-based decoder: an occupancy bitmask (bit i = element i nonzero) plus the packed nonzero values in ascending index order.
- Sits on the writer side of the sparse activation path, between the dense result buffer and the sparse memory writer.
- Accepts one chunk per handshake, emits one mask beat, then one value beat per nonzero element.

Parameters:
- CHUNK_N, 8, elements per chunk; power of two, 2..64; equals the mask width.
- ELEM_W, 8, element width in bits; elements are two's complement.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- dense_valid_i  input  1  dense chunk valid
- dense_ready_o  output  1  encoder can accept a chunk
- dense_data_i  input  CHUNK_N*ELEM_W  element i at bits [i*ELEM_W +: ELEM_W]
- mask_valid_o  output  1  mask beat valid
- mask_ready_i  input  1  mask beat accepted
- mask_o  output  CHUNK_N  occupancy bitmask, bit i = element i
- nnz_o  output  $clog2(CHUNK_N)+1  popcount of mask_o
- val_valid_o  output  1  value beat valid
- val_ready_i  input  1  value beat accepted
- val_o  output  ELEM_W  packed nonzero value
- val_idx_o  output  $clog2(CHUNK_N)  dense index of val_o
- val_last_o  output  1  final value beat of the chunk

Behaviour:
- Reset: all valids 0; dense_ready_o 0 while rst_i=1, 1 in the first cycle after release; mask_o, nnz_o, val_o, val_idx_o, val_last_o all 0; FSM in IDLE.
- FSM states: IDLE, SEND_MASK, SEND_VALS.
- IDLE: dense_ready_o=1.
  - On dense_valid_i && dense_ready_o, capture the data and compute the mask and nnz into registers; go to SEND_MASK.
  - dense_ready_o=0 in every other state (one chunk in flight).
- SEND_MASK: mask_valid_o=1 starting the cycle after acceptance (latency 1).
  - On mask_ready_i: if nnz=0, go to IDLE (no value beats); otherwise go to SEND_VALS.
- SEND_VALS: val_o/val_idx_o show the lowest-index set bit of the remaining-mask register.
  - On val_valid_o && val_ready_i, clear that bit.
  - val_last_o=1 when exactly one bit remains. The handshake on the last beat returns the FSM to IDLE.
- Throughput: with no backpressure, a chunk takes 1 (accept) + 1 (mask) + nnz cycles. The next chunk is accepted in the IDLE cycle that follows.
- Backpressure: while valid=1 and ready=0, every output of that channel holds stable. Valid never drops without a handshake.
- Zero test is exact equality to 0 in the default build.
- nnz_o range is 0..CHUNK_N. A full chunk gives nnz=CHUNK_N and needs the MSB, hence the extra bit.
- Ready inputs asserted while the corresponding valid is 0 are ignored.
- rst_i mid-chunk: the in-flight chunk is discarded with no further beats, and outputs return to reset values on the next edge.

Optional Feature:
- Macro: SPARSE_ENC_ZERO_THRESH_EN.
- Defined:
  - Adds input port thresh_i (ELEM_W-1 bits, unsigned).
  - An element counts as zero when |element| <= thresh_i. Magnitude of the most negative value = 2^(ELEM_W-1).
  - thresh_i is sampled only at chunk acceptance. Mask, nnz and values are computed from the same thresholded decision.
  - Suppressed elements are not emitted.
- Undefined: no thresh_i port; exact-zero test only.

Test Plan:
- Reset then idle: after rst_i release, dense_ready_o=1, mask_valid_o=0, val_valid_o=0. Hold rst_i 3 cycles: all outputs stay 0.
- Chunk {e0..e7}={0,5,0,0,7,0,0,9}, all readies=1 -> mask_o=8'b1001_0010 and nnz_o=3 on cycle+1. Then values 5/idx1, 7/idx4, 9/idx7 on cycles +2..+4, val_last_o only with 9. dense_ready_o=1 on cycle +5.
- All-zero chunk -> mask_o=0, nnz_o=0, no val_valid_o, back to IDLE right after the mask handshake. All-nonzero chunk {1..8} -> mask_o=8'hFF, nnz_o=8, 8 beats, last on idx7.
- Backpressure: same chunk with val_ready_i low for 3 cycles during beat 2 -> val_o=7, val_idx_o=4 held stable and not dropped or duplicated. mask_ready_i low 2 cycles -> mask held; a second dense_valid_i in this window is not accepted.
- rst_i asserted for 1 cycle after the first value beat of a 3-nnz chunk -> no further val_valid_o. The next chunk {0,0,3,0,0,0,0,0} encodes to mask 8'b0000_0100 with value 3, last.
- With SPARSE_ENC_ZERO_THRESH_EN, thresh_i=2, chunk {1,-2,3,-3,2,0,-128,127} -> mask 8'b1100_1100, nnz 4, values 3,-3,-128,127.

Source files
------------

// File: rtl/sparse_chunk_encoder.sv
// Dense-to-sparse chunk packer: one occupancy-mask beat, then one beat per nonzero element.
// Optional macro SPARSE_ENC_ZERO_THRESH_EN adds thresh_i for magnitude-threshold zero suppression.
module sparse_chunk_encoder #(
  parameter int unsigned CHUNK_N = 8,
  parameter int unsigned ELEM_W  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          dense_valid_i,
  output logic                          dense_ready_o,
  input  logic [CHUNK_N*ELEM_W-1:0]     dense_data_i,
`ifdef SPARSE_ENC_ZERO_THRESH_EN
  input  logic [ELEM_W-2:0]             thresh_i,
`endif
  output logic                          mask_valid_o,
  input  logic                          mask_ready_i,
  output logic [CHUNK_N-1:0]            mask_o,
  output logic [$clog2(CHUNK_N):0]      nnz_o,
  output logic                          val_valid_o,
  input  logic                          val_ready_i,
  output logic [ELEM_W-1:0]             val_o,
  output logic [$clog2(CHUNK_N)-1:0]    val_idx_o,
  output logic                          val_last_o
);

  localparam int unsigned IDX_W  = $clog2(CHUNK_N);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned DATA_W = CHUNK_N * ELEM_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_MASK = 2'd1,
    SEND_VALS = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   data_q, next_data;
  logic [CHUNK_N-1:0]  rem_q, next_rem, next_mask, mask_q;
  logic [CNT_W-1:0]    nnz_q, next_nnz;
  logic [ELEM_W-1:0]   val_q, next_val;
  logic [IDX_W-1:0]    idx_q, next_idx;
  logic                last_q, next_last;
  logic                accept, beat;

  function automatic logic [IDX_W-1:0] low_idx(input logic [CHUNK_N-1:0] m);
    low_idx = '0;
    for (int i = CHUNK_N - 1; i >= 0; i--) begin
      if (m[i]) low_idx = IDX_W'(i);
    end
  endfunction

  // Per-element occupancy decision and its popcount
  always_comb begin : mask_calc
    logic [ELEM_W-1:0] elem;
    logic [ELEM_W-1:0] mag;
    elem      = '0;
    mag       = '0;
    next_mask = '0;
    next_nnz  = '0;
    for (int i = 0; i < CHUNK_N; i++) begin
      elem = dense_data_i[i*ELEM_W +: ELEM_W];
`ifdef SPARSE_ENC_ZERO_THRESH_EN
      // Unsigned magnitude; the most negative value maps to 2^(ELEM_W-1)
      mag = elem[ELEM_W-1] ? ELEM_W'(~elem + ELEM_W'(1)) : elem;
      next_mask[i] = (mag > ELEM_W'(thresh_i));
`else
      mag = elem;
      next_mask[i] = (mag != '0);
`endif
      next_nnz = next_nnz + CNT_W'(next_mask[i]);
    end
  end

  // Remaining-mask walk; value-beat outputs are registered from the next remaining mask
  always_comb begin : walk_calc
    accept    = (state == IDLE) && dense_valid_i;
    beat      = (state == SEND_VALS) && val_ready_i;
    next_data = accept ? dense_data_i : data_q;
    next_rem  = rem_q;
    if (accept) begin
      next_rem = next_mask;
    end else if (beat) begin
      next_rem = rem_q & (rem_q - CHUNK_N'(1));
    end
    next_idx = low_idx(next_rem);
    next_val = '0;
    for (int i = 0; i < CHUNK_N; i++) begin
      if (next_idx == IDX_W'(i)) next_val = next_data[i*ELEM_W +: ELEM_W];
    end
    next_last = (next_rem != '0) && ((next_rem & (next_rem - CHUNK_N'(1))) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      rem_q  <= '0;
      mask_q <= '0;
      nnz_q  <= '0;
      val_q  <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      data_q <= next_data;
      rem_q  <= next_rem;
      val_q  <= next_val;
      idx_q  <= next_idx;
      last_q <= next_last;
      if (accept) begin
        mask_q <= next_mask;
        nnz_q  <= next_nnz;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (dense_valid_i) next_state = SEND_MASK;
      SEND_MASK: if (mask_ready_i) next_state = (nnz_q == '0) ? IDLE : SEND_VALS;
      SEND_VALS: if (val_ready_i && last_q) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dense_ready_o = 1'b0;
    mask_valid_o  = 1'b0;
    val_valid_o   = 1'b0;
    case (state)
      IDLE:      dense_ready_o = !rst_i;
      SEND_MASK: mask_valid_o  = 1'b1;
      SEND_VALS: val_valid_o   = 1'b1;
      default:   ;
    endcase
  end

  assign mask_o     = mask_q;
  assign nnz_o      = nnz_q;
  assign val_o      = val_q;
  assign val_idx_o  = idx_q;
  assign val_last_o = last_q;

endmodule
